// File: rtl/fir_axil_regs.sv
// AXI4-Lite control/status register file for the FIR filter: configuration
// fields, run/flush commands and a sequential coefficient-RAM write port.
module fir_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 9
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic                          cfg_mode,
   output logic [3:0]                    cfg_taps,
   output logic [3:0]                    cfg_shift,
   output logic [7:0]                    cfg_delay,
   output logic [7:0]                    cfg_last_tap,
   output logic                          fir_run,
   output logic                          fir_flush,
   output logic                          coef_we,
   output logic [7:0]                    coef_addr,
   output logic [15:0]                   coef_real,
   output logic [15:0]                   coef_imag
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   localparam logic [IDX_W-1:0] IDX_CONFIG  = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_COMMAND = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_COEF    = IDX_W'(3);

   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CMD_RUN   = C_S_AXI_DATA_WIDTH'(1);
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CMD_STOP  = C_S_AXI_DATA_WIDTH'(2);
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CMD_RSTP  = C_S_AXI_DATA_WIDTH'(3);
   localparam logic [C_S_AXI_DATA_WIDTH-1:0] CMD_FLUSH = C_S_AXI_DATA_WIDTH'(8);

   typedef struct packed {
      logic       mode;
      logic [3:0] taps;
      logic [3:0] shift;
      logic [7:0] delay;
      logic [7:0] last_tap;
   } cfg_t;

   // Write channel state
   logic             awready_q, awready_d;
   logic [IDX_W-1:0] awidx_q, awidx_d;
   logic             bvalid_q, bvalid_d;
   // Read channel state
   logic                          arready_q, arready_d;
   logic [IDX_W-1:0]              aridx_q, aridx_d;
   logic                          rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
   // Register file state
   cfg_t        cfg_q, cfg_d;
   logic        fir_run_q, fir_run_d;
   logic        fir_flush_q, fir_flush_d;
   logic [7:0]  coef_ptr_q, coef_ptr_d;
   logic        coef_full_q, coef_full_d;
   logic        coef_ovf_q, coef_ovf_d;
   logic        coef_we_q, coef_we_d;
   logic [7:0]  coef_addr_q, coef_addr_d;
   logic [15:0] coef_real_q, coef_real_d;
   logic [15:0] coef_imag_q, coef_imag_d;

   logic wr_start, wr_fire, rd_start, rd_fire;

   // Byte-lane bits of the addresses carry no information for word registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_start = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
   assign wr_fire  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_start = S_AXI_ARVALID && !arready_q && !rvalid_q;
   assign rd_fire  = arready_q && S_AXI_ARVALID;

   always_comb begin
      awready_d   = 1'b0;
      awidx_d     = awidx_q;
      bvalid_d    = bvalid_q;
      cfg_d       = cfg_q;
      fir_run_d   = fir_run_q;
      fir_flush_d = 1'b0;
      coef_ptr_d  = coef_ptr_q;
      coef_full_d = coef_full_q;
      coef_ovf_d  = coef_ovf_q;
      coef_we_d   = 1'b0;
      coef_addr_d = coef_addr_q;
      coef_real_d = coef_real_q;
      coef_imag_d = coef_imag_q;

      // The address is captured as AWREADY rises; later AWADDR changes are ignored.
      if (wr_start) begin
         awready_d = 1'b1;
         awidx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

      if (wr_fire) begin
         bvalid_d = 1'b1;
         case (awidx_q)
            IDX_CONFIG: begin
               cfg_d.mode     = S_AXI_WDATA[31];
               cfg_d.taps     = S_AXI_WDATA[30:27];
               cfg_d.shift    = S_AXI_WDATA[26:23];
               cfg_d.delay    = S_AXI_WDATA[22:15];
               cfg_d.last_tap = S_AXI_WDATA[7:0];
               coef_ptr_d     = 8'd0;
               coef_full_d    = 1'b0;
               coef_ovf_d     = 1'b0;
            end
            IDX_COMMAND: begin
               case (S_AXI_WDATA)
                  CMD_RUN:   if (coef_full_q) fir_run_d = 1'b1;
                  CMD_STOP:  fir_run_d = 1'b0;
                  CMD_RSTP: begin
                     coef_ptr_d  = 8'd0;
                     coef_full_d = 1'b0;
                     coef_ovf_d  = 1'b0;
                     fir_run_d   = 1'b0;
                  end
                  CMD_FLUSH: fir_flush_d = 1'b1;
                  default: ;
               endcase
            end
            IDX_COEF: begin
               if (coef_ptr_q <= cfg_q.last_tap) begin
                  coef_we_d   = 1'b1;
                  coef_addr_d = coef_ptr_q;
                  coef_real_d = S_AXI_WDATA[31:16];
                  coef_imag_d = S_AXI_WDATA[15:0];
                  if (coef_ptr_q == cfg_q.last_tap) coef_full_d = 1'b1;
                  if (coef_ptr_q != 8'hFF) coef_ptr_d = coef_ptr_q + 8'd1;
               end else begin
                  coef_ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      case (aridx_q)
         IDX_CONFIG: rd_word = {cfg_q.mode, cfg_q.taps, cfg_q.shift, cfg_q.delay,
                                7'd0, cfg_q.last_tap};
         IDX_STATUS: rd_word = {fir_run_q, 21'd0, coef_full_q, coef_ovf_q, coef_ptr_q};
         default:    rd_word = '0;
      endcase
   end

   // Read data is captured from pre-edge state, so a concurrent write is not visible.
   always_comb begin
      arready_d = 1'b0;
      aridx_d   = aridx_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rd_start) begin
         arready_d = 1'b1;
         aridx_d   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         awready_q   <= 1'b0;
         awidx_q     <= '0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         aridx_q     <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         cfg_q       <= '0;
         fir_run_q   <= 1'b0;
         fir_flush_q <= 1'b0;
         coef_ptr_q  <= 8'd0;
         coef_full_q <= 1'b0;
         coef_ovf_q  <= 1'b0;
         coef_we_q   <= 1'b0;
         coef_addr_q <= 8'd0;
         coef_real_q <= 16'd0;
         coef_imag_q <= 16'd0;
      end else begin
         awready_q   <= awready_d;
         awidx_q     <= awidx_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         aridx_q     <= aridx_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         cfg_q       <= cfg_d;
         fir_run_q   <= fir_run_d;
         fir_flush_q <= fir_flush_d;
         coef_ptr_q  <= coef_ptr_d;
         coef_full_q <= coef_full_d;
         coef_ovf_q  <= coef_ovf_d;
         coef_we_q   <= coef_we_d;
         coef_addr_q <= coef_addr_d;
         coef_real_q <= coef_real_d;
         coef_imag_q <= coef_imag_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;

   assign cfg_mode     = cfg_q.mode;
   assign cfg_taps     = cfg_q.taps;
   assign cfg_shift    = cfg_q.shift;
   assign cfg_delay    = cfg_q.delay;
   assign cfg_last_tap = cfg_q.last_tap;
   assign fir_run      = fir_run_q;
   assign fir_flush    = fir_flush_q;
   assign coef_we      = coef_we_q;
   assign coef_addr    = coef_addr_q;
   assign coef_real    = coef_real_q;
   assign coef_imag    = coef_imag_q;

endmodule

// File: tb/tb_fir_axil_regs.sv
// Directed bench for fir_axil_regs: handshakes, register decode, coefficient
// loading, commands, unmapped accesses and concurrent read/write.
module tb_fir_axil_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  S_AXI_AWADDR;
   logic        S_AXI_AWVALID, S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic        S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY;
   logic [8:0]  S_AXI_ARADDR;
   logic        S_AXI_ARVALID, S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID, S_AXI_RREADY;
   logic        cfg_mode;
   logic [3:0]  cfg_taps, cfg_shift;
   logic [7:0]  cfg_delay, cfg_last_tap;
   logic        fir_run, fir_flush, coef_we;
   logic [7:0]  coef_addr;
   logic [15:0] coef_real, coef_imag;

   int n_chk = 0;
   int n_fail = 0;
   int we_total = 0;
   int we_bad = 0;
   int flush_total = 0;

   always #5 clk = ~clk;

   fir_axil_regs dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .cfg_mode(cfg_mode), .cfg_taps(cfg_taps), .cfg_shift(cfg_shift), .cfg_delay(cfg_delay),
      .cfg_last_tap(cfg_last_tap), .fir_run(fir_run), .fir_flush(fir_flush),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_real(coef_real), .coef_imag(coef_imag)
   );

   // Coefficient writes carry {index, ~index}, so each strobe must match its own address.
   always @(negedge clk) begin
      if (!rst && coef_we) begin
         we_total <= we_total + 1;
         if (coef_real !== {8'h00, coef_addr} || coef_imag !== ~{8'h00, coef_addr})
            we_bad <= we_bad + 1;
      end
      if (!rst && fir_flush) flush_total <= flush_total + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic axi_write(input logic [8:0] addr, input logic [31:0] data);
      int k;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!S_AXI_AWREADY && k < 20);
      if (!S_AXI_AWREADY) begin
         n_chk++; n_fail++; $display("FAIL aw_timeout: addr %h not accepted", addr);
      end
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      k = 0;
      while (!S_AXI_BVALID && k < 20) begin @(posedge clk); #1; k++; end
      if (!S_AXI_BVALID) begin
         n_chk++; n_fail++; $display("FAIL b_timeout: addr %h no response", addr);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic axi_read(input logic [8:0] addr, output logic [31:0] d, output logic [1:0] r);
      int k;
      d = 32'hDEAD_BEEF; r = 2'b11;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!S_AXI_ARREADY && k < 20);
      @(posedge clk); #1;
      S_AXI_ARVALID = 1'b0;
      k = 0;
      while (!S_AXI_RVALID && k < 20) begin @(posedge clk); #1; k++; end
      if (!S_AXI_RVALID) begin
         n_chk++; n_fail++; $display("FAIL r_timeout: addr %h no data", addr);
      end else begin
         d = S_AXI_RDATA; r = S_AXI_RRESP;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r;
      rst = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
         n_fail++; $display("FAIL reset_handshake: got %b want 00000",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}); end
      n_chk++; if (S_AXI_RDATA !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 0", S_AXI_RDATA); end
      n_chk++; if ({cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap} !== 25'h0) begin
         n_fail++; $display("FAIL reset_cfg: got %h want 0",
            {cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap}); end
      n_chk++; if ({fir_run, fir_flush, coef_we, coef_addr, coef_real, coef_imag} !== 43'h0) begin
         n_fail++; $display("FAIL reset_ctrl: got %h want 0",
            {fir_run, fir_flush, coef_we, coef_addr, coef_real, coef_imag}); end
      rst = 1'b0;
      @(posedge clk); #1;
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b want 00", r); end
   endtask

   task automatic test_config_write();
      logic [31:0] d; logic [1:0] r; int bad;
      // Address valid only at the first edge, data arrives one cycle late.
      S_AXI_AWADDR = 9'h000; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      @(posedge clk); #1;
      n_chk++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin
         n_fail++; $display("FAIL cfg_ready: got %b want 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
      S_AXI_AWADDR = 9'h00C; S_AXI_WDATA = 32'h7D00_007F;
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_chk++; if (S_AXI_AWREADY !== 1'b0) begin
         n_fail++; $display("FAIL cfg_ready_pulse: got %b want 0", S_AXI_AWREADY); end
      n_chk++; if ({cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap} !==
                   {1'b0, 4'd15, 4'd10, 8'd0, 8'd127}) begin
         n_fail++; $display("FAIL cfg_fields: got %h want %h",
            {cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap},
            {1'b0, 4'd15, 4'd10, 8'd0, 8'd127}); end
      n_chk++; if (coef_we !== 1'b0) begin
         n_fail++; $display("FAIL cfg_addr_latch: coef_we got %b want 0", coef_we); end
      bad = 0;
      repeat (4) begin
         if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) bad++;
         @(posedge clk); #1;
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL cfg_bhold: got %0d bad cycles want 0", bad); end
      S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (S_AXI_BVALID !== 1'b0) begin
         n_fail++; $display("FAIL cfg_bclear: got %b want 0", S_AXI_BVALID); end
      axi_read(9'h000, d, r);
      n_chk++; if (d !== 32'h7D00_007F) begin n_fail++; $display("FAIL cfg_readback: got %h want 7d00007f", d); end
      axi_write(9'h000, 32'hFFFF_FFFF);
      n_chk++; if ({cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap} !==
                   {1'b1, 4'd15, 4'd15, 8'hFF, 8'hFF}) begin
         n_fail++; $display("FAIL cfg_ones: got %h want %h",
            {cfg_mode, cfg_taps, cfg_shift, cfg_delay, cfg_last_tap},
            {1'b1, 4'd15, 4'd15, 8'hFF, 8'hFF}); end
      axi_read(9'h000, d, r);
      n_chk++; if (d !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL cfg_reserved: got %h want ffff80ff", d); end
      axi_write(9'h000, 32'h7D00_007F);
   endtask

   task automatic test_coef_load();
      logic [31:0] d; logic [1:0] r; int w0, b0;
      w0 = we_total; b0 = we_bad;
      for (int i = 0; i < 128; i++) axi_write(9'h00C, {16'(i), ~16'(i)});
      #1;
      n_chk++; if (we_total - w0 != 128) begin n_fail++; $display("FAIL coef_count: got %0d want 128", we_total - w0); end
      n_chk++; if (we_bad - b0 != 0) begin n_fail++; $display("FAIL coef_data: got %0d bad want 0", we_bad - b0); end
      n_chk++; if (coef_addr !== 8'd127) begin n_fail++; $display("FAIL coef_last_addr: got %0d want 127", coef_addr); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0000_0280) begin n_fail++; $display("FAIL coef_status_full: got %h want 00000280", d); end
      w0 = we_total;
      axi_write(9'h00C, 32'h1234_5678);
      #1;
      n_chk++; if (we_total - w0 != 0) begin n_fail++; $display("FAIL coef_drop: got %0d strobes want 0", we_total - w0); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0000_0380) begin n_fail++; $display("FAIL coef_status_ovf: got %h want 00000380", d); end
   endtask

   task automatic test_commands();
      logic [31:0] d; logic [1:0] r; int f0;
      axi_write(9'h004, 32'd1);
      n_chk++; if (fir_run !== 1'b1) begin n_fail++; $display("FAIL cmd_run: got %b want 1", fir_run); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h8000_0380) begin n_fail++; $display("FAIL cmd_status_run: got %h want 80000380", d); end
      f0 = flush_total;
      axi_write(9'h004, 32'd8);
      #1;
      n_chk++; if (flush_total - f0 != 1) begin n_fail++; $display("FAIL cmd_flush_len: got %0d cycles want 1", flush_total - f0); end
      n_chk++; if (fir_run !== 1'b1) begin n_fail++; $display("FAIL cmd_flush_run: got %b want 1", fir_run); end
      axi_write(9'h004, 32'h0000_0102);
      n_chk++; if (fir_run !== 1'b1) begin n_fail++; $display("FAIL cmd_ignored: got %b want 1", fir_run); end
      axi_write(9'h004, 32'd2);
      n_chk++; if (fir_run !== 1'b0) begin n_fail++; $display("FAIL cmd_stop: got %b want 0", fir_run); end
      axi_read(9'h004, d, r);
      n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL cmd_read_zero: got %h want 0", d); end
   endtask

   task automatic test_reload();
      logic [31:0] d; logic [1:0] r; int w0, b0;
      axi_write(9'h004, 32'd1);
      axi_write(9'h004, 32'd3);
      n_chk++; if (fir_run !== 1'b0) begin n_fail++; $display("FAIL rld_run_clear: got %b want 0", fir_run); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rld_status_clear: got %h want 0", d); end
      axi_write(9'h000, 32'h7D00_007E);
      n_chk++; if (cfg_last_tap !== 8'd126) begin n_fail++; $display("FAIL rld_last_tap: got %0d want 126", cfg_last_tap); end
      w0 = we_total; b0 = we_bad;
      for (int i = 0; i < 128; i++) axi_write(9'h00C, {16'(i), ~16'(i)});
      #1;
      n_chk++; if (we_total - w0 != 127) begin n_fail++; $display("FAIL rld_count: got %0d want 127", we_total - w0); end
      n_chk++; if (we_bad - b0 != 0) begin n_fail++; $display("FAIL rld_data: got %0d bad want 0", we_bad - b0); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0000_037F) begin n_fail++; $display("FAIL rld_status: got %h want 0000037f", d); end
      axi_write(9'h004, 32'd3);
      axi_write(9'h004, 32'd1);
      n_chk++; if (fir_run !== 1'b0) begin n_fail++; $display("FAIL rld_run_gated: got %b want 0", fir_run); end
   endtask

   task automatic test_unmapped();
      logic [31:0] d; logic [1:0] r;
      axi_write(9'h014, 32'hFFFF_FFFF);
      axi_read(9'h000, d, r);
      n_chk++; if (d !== 32'h7D00_007E) begin n_fail++; $display("FAIL unm_cfg_kept: got %h want 7d00007e", d); end
      axi_read(9'h01C, d, r);
      n_chk++; if (d !== 32'h0 || r !== 2'b00) begin
         n_fail++; $display("FAIL unm_read: got %h/%b want 0/00", d, r); end
      axi_read(9'h00C, d, r);
      n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unm_coef_read: got %h want 0", d); end
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unm_status: got %h want 0", d); end
   endtask

   task automatic test_bready_stall();
      int bad;
      S_AXI_AWADDR = 9'h014; S_AXI_WDATA = 32'h0; S_AXI_BREADY = 1'b0;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      // Master keeps presenting the next write while the response is stalled.
      bad = 0;
      repeat (10) begin
         if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_BRESP !== 2'b00) bad++;
         @(posedge clk); #1;
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      n_chk++; if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b00) begin
         n_fail++; $display("FAIL stall_release: got %b want 00", {S_AXI_BVALID, S_AXI_AWREADY}); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d; logic [1:0] r;
      S_AXI_AWADDR = 9'h00C; S_AXI_WDATA = 32'h0000_FFFF; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 9'h008; S_AXI_ARVALID = 1'b1; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      n_chk++; if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11) begin
         n_fail++; $display("FAIL sim_ready: got %b want 11", {S_AXI_AWREADY, S_AXI_ARREADY}); end
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      n_chk++; if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL sim_prewrite: got %b/%b/%h want 1/1/00000000",
            S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA); end
      @(posedge clk); #1;
      axi_read(9'h008, d, r);
      n_chk++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL sim_postwrite: got %h want 00000001", d); end
   endtask

   initial begin
      test_reset();
      test_config_write();
      test_coef_load();
      test_commands();
      test_reload();
      test_unmapped();
      test_bready_stall();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
